pdu_ctrl: RTL
=============

PDU_CTRL -- requirements
Module: pdu_ctrl

Interface
REQ-001 SHALL provide cpu_clk  input  1  single clock, rising edge.
REQ-002 SHALL provide cpu_rstn  input  1  asynchronous active-low reset.
REQ-003 SHALL provide run  input  1  run request, debounced and synchronous; acts on its rising edge.
REQ-004 SHALL provide step  input  1  single-step request; acts on its rising edge.
REQ-005 SHALL provide stop  input  1  halt/abort request; acts on its rising edge.
REQ-006 SHALL provide brk_en  input  1  breakpoint enable.
REQ-007 SHALL provide brk_pc  input  32  breakpoint address.
REQ-008 SHALL provide pc  input  32  CPU IF-stage PC.
REQ-009 SHALL provide dbg_ra  input  6  external register-inspect address.
REQ-010 SHALL provide rrd0  input  32  CPU RF debug read data (combinational from rra0).
REQ-011 SHALL provide dump_req  input  1  start register dump (level).
REQ-012 SHALL provide dump_ready  input  1  consumer accepts dump word.
REQ-013 SHALL provide cpu_en  output  1  CPU clock enable.
REQ-014 SHALL provide rra0  output  6  RF debug read address to CPU.
REQ-015 SHALL provide dump_data  output  32, dump_valid  output  1, dump_idx  output  5, dump_last  output  1  dump stream.
REQ-016 SHALL provide state  output  2, halted  output  1, brk_hit  output  1, cyc_cnt  output  32  status.

Function
REQ-017 States SHALL be IDLE=00, RUN=01, STEP=10, DUMP=11; halted SHALL be 1 iff state==IDLE.
REQ-018 Rising edge SHALL be defined as input high this cycle and registered previous sample low; one prev register per run/step/stop.
REQ-019 IDLE: run rise -> RUN, else step rise -> STEP, else dump_req -> DUMP (priority run > step > dump).
REQ-020 RUN: cpu_en=1 every cycle except a breakpoint-match cycle; match = brk_en && pc==brk_pc, combinational.
REQ-021 RUN: match SHALL force cpu_en=0 that cycle, set brk_hit, and go to IDLE; match SHALL be ignored in the first RUN cycle after entry so a resume from a breakpoint advances.
REQ-022 RUN: stop rise -> IDLE with cpu_en=0 that cycle; stop takes priority over match.
REQ-023 STEP: cpu_en=1 for exactly one cycle, breakpoint ignored, then IDLE unconditionally.
REQ-024 brk_hit SHALL be sticky and clear on the next run or step rise.
REQ-025 cpu_en SHALL be 0 in IDLE and DUMP.
REQ-026 rra0 SHALL equal {1'b0,dump_idx} in DUMP, else dbg_ra.
REQ-027 DUMP entry SHALL set dump_idx=0, dump_valid=0.
REQ-028 In DUMP with dump_valid=0, the next edge SHALL capture rrd0 into dump_data and set dump_valid=1.
REQ-029 dump_data/dump_idx SHALL hold while dump_valid && !dump_ready.
REQ-030 On dump_valid && dump_ready: idx<31 -> idx+1, valid=0; idx==31 -> valid=0, state IDLE.
REQ-031 dump_last SHALL equal dump_valid && dump_idx==31.
REQ-032 stop rise in DUMP SHALL abort to IDLE next edge with dump_valid=0, idx=0.
REQ-033 cyc_cnt SHALL increment by 1 on each edge where cpu_en=1, wrapping 0xFFFFFFFF -> 0.
REQ-034 run/step rises in RUN/STEP/DUMP SHALL be ignored.

Reset
REQ-035 cpu_rstn low SHALL immediately force state=IDLE, cpu_en=0, rra0=dbg_ra, dump_data=0, dump_valid=0, dump_idx=0, brk_hit=0, cyc_cnt=0, all prev samples=0, first-cycle flag=0.
REQ-036 Reset during DUMP or RUN SHALL abandon the operation; no pending request survives deassertion.

Structure
REQ-037 State encodings and the dump length constant (32) SHALL live in the shared pdu package.
REQ-038 Edge detection SHALL be one sub-module, edge_rise, instanced three times; FSM, dump sequencer and counter stay in pdu_ctrl.

Verification
REQ-039 Reset, then step pulse with pc=0x0 -> cpu_en high exactly 1 cycle, cyc_cnt=1, state back to 00.
REQ-040 brk_en=1, brk_pc=0x10, run pulse, pc advancing by 4 per enabled cycle from 0 -> cpu_en low when pc=0x10, brk_hit=1, cyc_cnt=4; second run pulse -> pc=0x10 executes, brk_hit=0.
REQ-041 Dump with dump_ready=1, rrd0=0xA0+rra0 -> 32 words 0xA0..0xBF, dump_last only on idx 31, then IDLE.
REQ-042 Dump with dump_ready low 5 cycles at idx 3 -> dump_data=0xA3 and idx=3 held, no word lost or duplicated.
REQ-043 stop rise at idx 10 in DUMP -> IDLE next edge, dump_valid=0; simultaneous stop and match in RUN -> IDLE, cpu_en=0.
REQ-044 Preload-free wrap: force run for 2^32 enabled cycles (or via reduced-width parameter) -> cyc_cnt wraps to 0; cpu_rstn low mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pdu_ctrl_pkg.sv
// Shared definitions for the debug/run-control unit (PDU).
//   pdu_state_t : controller state encoding, also exported on the state port
//   DUMP_LEN    : number of register-file words streamed by a dump
//   IDX_W       : width of the dump word index
//   IDX_LAST    : index of the final dump word
package pdu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DUMP = 2'b11
    } pdu_state_t;

    localparam int DUMP_LEN = 32;
    localparam int IDX_W    = $clog2(DUMP_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DUMP_LEN - 1);

endpackage

// File: rtl/pdu_ctrl_if.sv
// Register-dump stream between the PDU and its consumer.
//   dump_data  : register word for index dump_idx
//   dump_valid : dump_data/dump_idx are presented
//   dump_idx   : register index of the presented word
//   dump_last  : presented word is the final one of the dump
//   dump_ready : consumer accepts the presented word this cycle
// master = PDU side, slave = consumer side.
interface pdu_ctrl_if;

    logic [31:0]                    dump_data;
    logic                           dump_valid;
    logic [pdu_ctrl_pkg::IDX_W-1:0] dump_idx;
    logic                           dump_last;
    logic                           dump_ready;

    modport master (
        output dump_data,
        output dump_valid,
        output dump_idx,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_data,
        input  dump_valid,
        input  dump_idx,
        input  dump_last,
        output dump_ready
    );

endinterface

// File: rtl/pdu_ctrl_edge_rise.sv
// Rising-edge detector for a synchronous request line.
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : request level
//   rise       : din high now while the previous-cycle sample was low
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/pdu_ctrl.sv
// Run-control and register-dump unit for a CPU debug port.
//   cpu_clk, cpu_rstn   : clock and asynchronous active-low reset
//   run, step, stop     : control requests, acted on at their rising edge
//   brk_en, brk_pc, pc  : breakpoint enable/address and CPU IF-stage PC
//   dbg_ra              : external register-inspect address
//   rrd0                : CPU register-file debug read data (for rra0)
//   dump_req            : start a register dump (level)
//   cpu_en              : CPU clock enable
//   rra0                : register-file debug read address to the CPU
//   state, halted       : controller state, high when idle
//   brk_hit             : sticky breakpoint-taken flag
//   cyc_cnt             : count of enabled CPU cycles (CNT_W bits, wraps)
//   dump                : register-dump stream (master side)
module pdu_ctrl import pdu_ctrl_pkg::*; #(
    parameter int CNT_W = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    input  logic             run,
    input  logic             step,
    input  logic             stop,
    input  logic             brk_en,
    input  logic [31:0]      brk_pc,
    input  logic [31:0]      pc,
    input  logic [5:0]       dbg_ra,
    input  logic [31:0]      rrd0,
    input  logic             dump_req,
    output logic             cpu_en,
    output logic [5:0]       rra0,
    output logic [1:0]       state,
    output logic             halted,
    output logic             brk_hit,
    output logic [CNT_W-1:0] cyc_cnt,
    pdu_ctrl_if.master       dump
);

    pdu_state_t st;
    logic       first_q;      // high during the first RUN cycle after entry
    logic       run_rise, step_rise, stop_rise;
    logic       match;

    edge_rise u_run_rise  (.clk(cpu_clk), .rst_n(cpu_rstn), .din(run),  .rise(run_rise));
    edge_rise u_step_rise (.clk(cpu_clk), .rst_n(cpu_rstn), .din(step), .rise(step_rise));
    edge_rise u_stop_rise (.clk(cpu_clk), .rst_n(cpu_rstn), .din(stop), .rise(stop_rise));

    assign match = brk_en && (pc == brk_pc);

    // NOTE: cpu_en must gate the very cycle where the breakpoint PC or the
    // stop edge appears, so it is decoded from state and live inputs rather
    // than registered; registering it would let that instruction execute.
    // The first RUN cycle ignores the match so a resume steps off the breakpoint.
    assign cpu_en = (st == ST_STEP) ||
                    ((st == ST_RUN) && !stop_rise && !(match && !first_q));

    assign rra0           = (st == ST_DUMP) ? {1'b0, dump.dump_idx} : dbg_ra;
    assign state          = st;
    assign halted         = (st == ST_IDLE);
    assign dump.dump_last = dump.dump_valid && (dump.dump_idx == IDX_LAST);

    // NOTE: every register here is assigned with <= so all next-state terms
    // read the pre-edge values; blocking updates would leak new values
    // into later decisions in the same block.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            st              <= ST_IDLE;
            first_q         <= 1'b0;
            brk_hit         <= 1'b0;
            dump.dump_data  <= '0;
            dump.dump_valid <= 1'b0;
            dump.dump_idx   <= '0;
        end else begin
            first_q <= 1'b0;
            unique case (st)
                ST_IDLE: begin
                    if (run_rise) begin
                        st      <= ST_RUN;
                        first_q <= 1'b1;
                        brk_hit <= 1'b0;
                    end else if (step_rise) begin
                        st      <= ST_STEP;
                        brk_hit <= 1'b0;
                    end else if (dump_req) begin
                        st              <= ST_DUMP;
                        dump.dump_idx   <= '0;
                        dump.dump_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop_rise) begin
                        st <= ST_IDLE;
                    end else if (match && !first_q) begin
                        st      <= ST_IDLE;
                        brk_hit <= 1'b1;
                    end
                end
                ST_STEP: st <= ST_IDLE;
                ST_DUMP: begin
                    if (stop_rise) begin
                        st              <= ST_IDLE;
                        dump.dump_valid <= 1'b0;
                        dump.dump_idx   <= '0;
                    end else if (!dump.dump_valid) begin
                        // rra0 already points at dump_idx, so rrd0 is that register
                        dump.dump_data  <= rrd0;
                        dump.dump_valid <= 1'b1;
                    end else if (dump.dump_ready) begin
                        dump.dump_valid <= 1'b0;
                        if (dump.dump_idx == IDX_LAST) begin
                            st            <= ST_IDLE;
                            dump.dump_idx <= '0;
                        end else begin
                            dump.dump_idx <= dump.dump_idx + IDX_W'(1);
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn)   cyc_cnt <= '0;
        else if (cpu_en) cyc_cnt <= cyc_cnt + CNT_W'(1);
    end

endmodule
